// File: rtl/insn_fetch.sv
// insn_fetch: instruction fetch stage feeding the execute stage.
//
// Owns the program counter, issues reads to a synchronous instruction memory
// (1-cycle read latency), buffers returned instructions together with their PC
// in a small circular FIFO and presents the head downstream on valid/ready.
// A taken-branch redirect flushes the FIFO, drops any in-flight return and
// restarts fetch at the redirect target.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   o_imem_en      instruction memory read enable
//   o_imem_addr    read address (current fetch PC)
//   i_imem_data    read data, valid the cycle after o_imem_en
//   o_valid        FIFO head holds an instruction
//   o_insn         head instruction (0 when !o_valid)
//   o_pc           PC of head instruction (0 when !o_valid)
//   i_ready        downstream accepts head this cycle
//   i_redirect     taken branch: flush and refetch
//   i_redirect_pc  new fetch target
module insn_fetch #(
    parameter int unsigned     INSN     = 19,
    parameter int unsigned     IADDR    = 10,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [IADDR:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_imem_en,
    output logic [IADDR:0]   o_imem_addr,
    input  logic [INSN:0]    i_imem_data,
    output logic             o_valid,
    output logic [INSN:0]    o_insn,
    output logic [IADDR:0]   o_pc,
    input  logic             i_ready,
    input  logic             i_redirect,
    input  logic [IADDR:0]   i_redirect_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    // Architectural state
    logic [IADDR:0] fetch_pc_q, fetch_pc_d;
    logic           inflight_q, inflight_d;
    logic [IADDR:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // FIFO storage; contents are only observed through count, so no reset
    logic [INSN:0]  mem_insn [DEPTH];
    logic [IADDR:0] mem_pc   [DEPTH];

    logic           pop_raw;
    logic           pop;
    logic           push;
    logic [CW:0]    occupancy;
    logic           issue;

    assign o_valid = (count_q != '0);
    assign pop_raw = o_valid & i_ready;
    // A redirect voids the pop and drops the return: the flush wins.
    assign pop     = pop_raw & ~i_redirect;
    assign push    = inflight_q & ~i_redirect;

    // Slots committed after this cycle; one spare bit so the sum never wraps.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_raw};

    // rst_n gates issue so the enable drops the instant reset asserts.
    assign issue       = rst_n & ~i_redirect & (occupancy < DepthW);
    assign o_imem_en   = issue;
    assign o_imem_addr = fetch_pc_q;

    assign o_insn = o_valid ? mem_insn[rd_ptr_q] : '0;
    assign o_pc   = o_valid ? mem_pc[rd_ptr_q]   : '0;

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 1'b1;  // wraps modulo 2^(IADDR+1)
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;         // DEPTH is a power of two
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wr_ptr_q] <= i_imem_data;
            mem_pc[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: two instances (RESET_PC 0 and 7FE), a shared
// instruction memory model, and a queue of expected accepted PCs.
module tb_insn_fetch;

    logic         clk;
    logic         rst_n;
    logic         ready;
    logic         redirect;
    logic [10:0]  redirect_pc;

    logic         en0, valid0;
    logic [10:0]  addr0, pc0;
    logic [19:0]  data0, insn0;

    logic         en1, valid1;
    logic [10:0]  addr1, pc1;
    logic [19:0]  data1, insn1;

    logic [19:0]  imem [2048];
    logic [10:0]  q [$];

    int n_cmp;
    int n_err;

    insn_fetch #(.INSN(19), .IADDR(10), .DEPTH(2), .RESET_PC(11'h000)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_en(en0), .o_imem_addr(addr0), .i_imem_data(data0),
        .o_valid(valid0), .o_insn(insn0), .o_pc(pc0),
        .i_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
    );

    insn_fetch #(.INSN(19), .IADDR(10), .DEPTH(2), .RESET_PC(11'h7FE)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .o_imem_en(en1), .o_imem_addr(addr1), .i_imem_data(data1),
        .o_valid(valid1), .o_insn(insn1), .o_pc(pc1),
        .i_ready(1'b1), .i_redirect(1'b0), .i_redirect_pc(11'h000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one read port per instance
    always @(posedge clk) begin
        if (en0) data0 <= imem[addr0];
        if (en1) data1 <= imem[addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted head must be the next expected PC; a stalled head must be too.
    task automatic scoreboard();
        logic [10:0] e;
        if (valid0 && ready && !redirect) begin
            chk("queue_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("acc_pc", 32'(pc0), 32'(e));
                chk("acc_insn", 32'(insn0), 32'(imem[e]));
            end
        end else if (valid0 && !ready && q.size() != 0) begin
            chk("stall_pc", 32'(pc0), 32'(q[0]));
            chk("stall_insn", 32'(insn0), 32'(imem[q[0]]));
        end
    endtask

    task automatic obs();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] hp;
        n_cmp = 0;
        n_err = 0;
        for (int n = 0; n < 2048; n++) imem[n] = 20'(n);
        rst_n       = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        obs();
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_insn", 32'(insn0), 32'd0);
        chk("rst_pc", 32'(pc0), 32'd0);
        chk("rst_en", 32'(en0), 32'd0);
        chk("rst_en_hi", 32'(en1), 32'd0);
        nxt();
        rst_n = 1'b1;

        // Streaming with a stall window in cycles 4..7
        for (int n = 0; n <= 8; n++) q.push_back(11'(n));
        for (int c = 0; c < 15; c++) begin
            ready = !(c >= 4 && c <= 7);
            obs();
            if (c == 0) begin
                chk("c0_en", 32'(en0), 32'd1);
                chk("c0_addr", 32'(addr0), 32'd0);
                chk("c0_valid", 32'(valid0), 32'd0);
            end
            if (c == 1) chk("c1_valid", 32'(valid0), 32'd0);
            if (c == 2) begin
                chk("c2_valid", 32'(valid0), 32'd1);
                chk("c2_pc", 32'(pc0), 32'd0);
            end
            if (c == 4) chk("stall_en_drop", 32'(en0), 32'd0);
            if (c == 5) begin
                chk("stall_en_held", 32'(en0), 32'd0);
                chk("stall_addr_held", 32'(addr0), 32'd4);
            end
            if (c == 8) chk("resume_en", 32'(en0), 32'd1);
            nxt();
        end

        // Redirect with FIFO non-empty
        chk("q_drained", 32'(q.size()), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 11'h155;
        obs();
        chk("rd_T_en", 32'(en0), 32'd0);
        chk("rd_T_valid", 32'(valid0), 32'd1);
        chk("rd_T_pc", 32'(pc0), 32'd9);
        nxt();
        redirect = 1'b0;
        for (int n = 0; n < 4; n++) q.push_back(11'(11'h155 + n));
        for (int k = 1; k <= 6; k++) begin
            obs();
            if (k == 1) begin
                chk("rd_T1_valid", 32'(valid0), 32'd0);
                chk("rd_T1_en", 32'(en0), 32'd1);
                chk("rd_T1_addr", 32'(addr0), 32'h155);
            end
            if (k == 2) chk("rd_T2_valid", 32'(valid0), 32'd0);
            if (k == 3) begin
                chk("rd_T3_valid", 32'(valid0), 32'd1);
                chk("rd_T3_pc", 32'(pc0), 32'h155);
            end
            nxt();
        end

        // Fill the FIFO under backpressure, then back-to-back redirects
        q.push_back(11'h159);
        q.push_back(11'h15A);
        ready = 1'b0;
        obs();
        chk("fill_en0", 32'(en0), 32'd0);
        nxt();
        obs();
        chk("full_en", 32'(en0), 32'd0);
        nxt();
        redirect    = 1'b1;
        redirect_pc = 11'h040;
        obs();
        chk("b2b_T_en", 32'(en0), 32'd0);
        chk("b2b_T_valid", 32'(valid0), 32'd1);
        nxt();
        q.delete();
        redirect_pc = 11'h080;
        ready       = 1'b1;
        obs();
        chk("b2b_T1_valid", 32'(valid0), 32'd0);
        chk("b2b_T1_en", 32'(en0), 32'd0);
        nxt();
        redirect = 1'b0;
        for (int n = 0; n < 3; n++) q.push_back(11'(11'h080 + n));
        for (int j = 2; j <= 6; j++) begin
            obs();
            if (j == 2) begin
                chk("b2b_T2_en", 32'(en0), 32'd1);
                chk("b2b_T2_addr", 32'(addr0), 32'h080);
                chk("b2b_T2_valid", 32'(valid0), 32'd0);
            end
            if (j == 3) chk("b2b_T3_valid", 32'(valid0), 32'd0);
            if (j == 4) begin
                chk("b2b_T4_valid", 32'(valid0), 32'd1);
                chk("b2b_T4_pc", 32'(pc0), 32'h080);
            end
            nxt();
        end

        // Asynchronous reset mid-stream
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid0), 32'd0);
        chk("arst_en", 32'(en0), 32'd0);
        chk("arst_pc", 32'(pc0), 32'd0);
        chk("arst_insn", 32'(insn0), 32'd0);
        chk("arst_en_hi", 32'(en1), 32'd0);
        q.delete();
        obs();
        nxt();
        obs();
        nxt();
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) q.push_back(11'(n));
        for (int c = 0; c < 6; c++) begin
            obs();
            if (c == 0) begin
                chk("rel_en", 32'(en0), 32'd1);
                chk("rel_addr", 32'(addr0), 32'd0);
                chk("rel_valid", 32'(valid0), 32'd0);
            end
            if (c == 1) chk("rel_c1_valid", 32'(valid0), 32'd0);
            if (c == 2) begin
                chk("rel_c2_valid", 32'(valid0), 32'd1);
                chk("rel_c2_pc", 32'(pc0), 32'd0);
            end
            if (c >= 2) begin
                hp = 11'(11'h7FE + 11'(c - 2));
                chk("hi_valid", 32'(valid1), 32'd1);
                chk("hi_pc", 32'(pc1), 32'(hp));
                chk("hi_insn", 32'(insn1), 32'(imem[hp]));
            end
            nxt();
        end
        chk("final_q_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
